reg_rr_arbiter: RTL and testbench
=================================

// Module: reg_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one WIDTH-bit register, built from D flip-flops, between N_REQ requesters.
//  Grants exactly one owner at a time. The owner's data is written into the shared register each granted cycle.
//  A hold limit prevents starvation. Sits between requesting datapath blocks and the shared storage register.
// PARAMETERS
//  N_REQ    4  number of requesters (2..8)
//  WIDTH    8  shared register width
//  MAX_HOLD 4  max consecutive grant cycles while others wait (>=1)
// PORTS
//  clk      in   1            clock, rising edge
//  reset_n  in   1            asynchronous, active-low reset
//  clr      in   1            synchronous clear of shared register, active-high
//  req      in   N_REQ        request per requester; owner holds high to keep ownership
//  wdata    in   N_REQ*WIDTH  packed write data; requester i drives wdata[i*WIDTH +: WIDTH]
//  grant    out  N_REQ        one-hot grant, registered; all-zero when idle
//  busy     out  1            high while any grant is active
//  owner    out  clog2(N_REQ) index of current owner; 0 when idle
//  q        out  WIDTH        shared register contents
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; grant=0, busy=0, owner=0, q=0.
//   - rr pointer ptr=0, so requester 0 has top priority first; hold_cnt=0.
//   - Reset mid-ownership drops the grant immediately and does not write q.
//  FSM states: IDLE, BUSY. All decisions use req sampled at the rising edge.
//  IDLE:
//   - any req -> BUSY; owner=rr_pick(req,ptr), i.e. the first set bit scanning ptr, ptr+1, .. mod N_REQ.
//   - Set hold_cnt=1.
//  BUSY, owner k:
//   - Stay when req[k]=1 and (hold_cnt<MAX_HOLD or no other req).
//     hold_cnt increments, saturating at MAX_HOLD.
//   - Release when req[k]=0, or when hold_cnt==MAX_HOLD and another req is pending.
//     Release sets ptr=(k+1) mod N_REQ.
//     If other = req & ~(1<<k) is nonzero: hand off with no bubble.
//     The new owner is rr_pick(other,(k+1) mod N_REQ); hold_cnt=1.
//     Otherwise go to IDLE.
//  Latency:
//   - req high at edge t -> grant high after edge t (1 cycle).
//   - First write into q at edge t+1.
//  Write rule: at each edge where grant[k]=1 and req[k]=1, q <= wdata[k].
//   - No write when the owner has dropped req (release cycle).
//   - clr=1 forces q <= 0 and has priority over the write. clr does not affect arbitration.
//  Invariants: grant is zero or one-hot; busy == |grant; owner is the index of the set grant bit.
//  Wrap: after release by requester N_REQ-1, ptr=0.
//  Simultaneous requests: rr order from ptr decides; no fixed priority apart from the reset value of ptr.
//  hold_cnt width is clog2(MAX_HOLD+1). Arithmetic is unsigned.
// STRUCTURE
//  Package reg_arb_pkg:
//   - state encoding (IDLE=1'b0, BUSY=1'b1)
//   - clog2 function for the owner/ptr/hold_cnt widths
//  Sub-module rr_priority_pick (combinational):
//   - inputs req_vec and start index; outputs found and idx.
//   - Used once for the IDLE pick and once for the handoff pick.
//  Top module: FSM, ptr/hold_cnt/owner registers, shared q register with async reset, sync clr and write enable.
// TESTING
//  1 Reset: drive reset_n=0 with random req/wdata -> grant=0, busy=0, owner=0, q=0.
//    Deassert reset_n with req=0 -> all outputs stay 0.
//  2 Single requester: req=4'b0100, wdata[2]=8'hA5 -> grant=4'b0100 one cycle later; q=8'hA5 one edge after that.
//    Drop req -> grant=0 the next cycle; q holds 8'hA5.
//  3 Simultaneous: req=4'b1111 held, MAX_HOLD=4 -> grant 0001 for 4 cycles, then 0010, 0100, 1000, then 0001 again.
//    Each handoff has no idle cycle between grants.
//  4 Hold with no contention: req=4'b0001 for 10 cycles -> grant=0001 for all 10 cycles; hold_cnt saturates at 4.
//    Raise req[3] -> next cycle grant=1000.
//  5 clr priority: owner 1 writes 8'h3C while clr=1 -> q=8'h00.
//    Next edge with clr=0 -> q=8'h3C; grant unaffected.
//  6 Reset mid-op: pulse reset_n low asynchronously during a grant of requester 2 -> grant=0, q=0 immediately.
//    After release with req=4'b0101 -> requester 0 is granted first (ptr=0).

Source files
------------

// File: rtl/reg_rr_arbiter_pkg.sv
// reg_arb_pkg: FSM encoding and width helper shared by the round-robin register arbiter.
package reg_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/reg_rr_arbiter_pick.sv
// rr_priority_pick: first set bit of req_vec scanning start, start+1, .. modulo N.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset down so the nearest set bit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_vec[(int'(start) + i) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(start) + i) % N);
            end
    end

endmodule

// File: rtl/reg_rr_arbiter.sv
// reg_rr_arbiter: round-robin ownership of one shared register with a bounded hold under contention.
module reg_rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    localparam int IW      = clog2(N_REQ),
    localparam int HW      = clog2(MAX_HOLD + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [IW-1:0]          owner,
    output logic [WIDTH-1:0]       q
);

    state_t           state, state_d;
    logic [IW-1:0]    owner_d, ptr, ptr_d, nxt, idle_idx, ho_idx;
    logic [HW-1:0]    hold_cnt, hold_d;
    logic [N_REQ-1:0] other;
    logic             idle_found, ho_found, own_req, at_max, rel;

    assign other   = req & ~grant;
    assign own_req = |(req & grant);
    assign at_max  = hold_cnt == HW'(MAX_HOLD);
    assign rel     = !own_req || (at_max && |other);
    assign nxt     = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy    = |grant;

    rr_priority_pick #(.N(N_REQ), .IW(IW)) u_idle_pick (
        .req_vec (req),
        .start   (ptr),
        .found   (idle_found),
        .idx     (idle_idx)
    );

    rr_priority_pick #(.N(N_REQ), .IW(IW)) u_ho_pick (
        .req_vec (other),
        .start   (nxt),
        .found   (ho_found),
        .idx     (ho_idx)
    );

    always_comb begin
        state_d = state;
        owner_d = owner;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        if (state == IDLE) begin
            if (idle_found) begin
                state_d = BUSY;
                owner_d = idle_idx;
                hold_d  = HW'(1);
            end
        end else if (rel) begin
            ptr_d   = nxt;
            state_d = ho_found ? BUSY : IDLE;
            owner_d = ho_found ? ho_idx : '0;
            hold_d  = ho_found ? HW'(1) : '0;
        end else begin
            hold_d  = at_max ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            q        <= '0;
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
            grant    <= (state_d == BUSY) ? N_REQ'(1) << owner_d : '0;
            q        <= clr ? '0 : own_req ? wdata[owner*WIDTH +: WIDTH] : q;
        end
    end

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// tb_reg_rr_arbiter: directed and random stimulus checked against a behavioural arbiter model.
module tb_reg_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk = 0;
    logic           reset_n = 0;
    logic           clr = 0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [1:0]     owner;
    logic [W-1:0]   q;

    int n_chk = 0, n_pass = 0;
    int m_busy, m_owner, m_ptr, m_hold;
    logic [W-1:0] m_q;

    reg_rr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .req     (req),
        .wdata   (wdata),
        .grant   (grant),
        .busy    (busy),
        .owner   (owner),
        .q       (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int s);
        for (int i = 0; i < N; i++)
            if (v[(s + i) % N]) return (s + i) % N;
        return 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_q = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] oth;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (clr) m_q = '0;
        else if (m_busy != 0 && req[m_owner]) m_q = wdata[m_owner*W +: W];
        if (m_busy == 0) begin
            if (req != 0) begin
                m_owner = pick(req, m_ptr);
                m_busy  = 1;
                m_hold  = 1;
            end
        end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            if (req[m_owner] && (m_hold < MH || oth == 0)) begin
                m_hold = (m_hold < MH) ? m_hold + 1 : MH;
            end else begin
                m_ptr = (m_owner + 1) % N;
                if (oth != 0) begin
                    m_owner = pick(oth, m_ptr);
                    m_hold  = 1;
                end else begin
                    m_busy  = 0;
                    m_owner = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] eg;
        eg = (m_busy != 0) ? N'(1) << m_owner : '0;
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_busy"},  32'(busy),  32'(m_busy));
        chk({tag, "_owner"}, 32'(owner), 32'(m_owner));
        chk({tag, "_q"},     32'(q),     32'(m_q));
        if (m_busy != 0) chk({tag, "_hold"}, 32'(dut.hold_cnt), 32'(m_hold));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic go_idle();
        req = '0; clr = 0;
        step("idle");
        step("idle");
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) begin
            req   = N'($urandom);
            wdata = {$urandom, $urandom};
            step("rst");
        end
        chk("rst_q_zero", 32'(q), 32'h0);
        req = '0;
        #2 reset_n = 1;
        for (int i = 0; i < 3; i++) step("post_rst");

        req = 4'b0100; wdata = '0; wdata[2*W +: W] = 8'hA5;
        step("single");
        chk("single_grant", 32'(grant), 32'h4);
        step("single");
        chk("single_q", 32'(q), 32'hA5);
        req = '0;
        step("single_drop");
        chk("single_drop_grant", 32'(grant), 32'h0);
        chk("single_hold_q", 32'(q), 32'hA5);

        req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            wdata = {$urandom, $urandom};
            step("simul");
        end
        go_idle();

        req = 4'b0001;
        for (int i = 0; i < 10; i++) step("nocont");
        chk("nocont_sat", 32'(dut.hold_cnt), 32'(MH));
        req = 4'b1001;
        step("nocont_raise");
        chk("nocont_raise_grant", 32'(grant), 32'h8);
        go_idle();

        req = 4'b0010; wdata = '0; wdata[1*W +: W] = 8'h3C;
        step("clr");
        clr = 1;
        step("clr_on");
        chk("clr_on_q", 32'(q), 32'h0);
        clr = 0;
        step("clr_off");
        chk("clr_off_q", 32'(q), 32'h3C);
        chk("clr_off_grant", 32'(grant), 32'h2);
        go_idle();

        for (int i = 0; i < 400; i++) begin
            req   = ($urandom_range(0, 3) == 0) ? N'($urandom) : req;
            wdata = {$urandom, $urandom};
            clr   = ($urandom_range(0, 7) == 0);
            step("rand");
        end
        go_idle();

        req = 4'b0100; wdata = {$urandom, $urandom};
        step("midrst");
        step("midrst");
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_q", 32'(q), 32'h0);
        @(negedge clk);
        reset_n = 1;
        req = 4'b0101;
        step("after_rst");
        chk("after_rst_grant", 32'(grant), 32'h1);
        step("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
